// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, next-PC selection and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx,
    input  logic [31:0] jr_addr,
    output logic [29:0] pc,
    input  logic [31:0] im_ir,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    logic [29:0] pc_q, pc_d;
    logic [31:0] ifid_ir_q, ifid_ir_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        redirect;
    logic        load;
    logic [29:0] target;
    logic [29:0] pc_inc;
    logic        unused_bits;

    assign unused_bits = ^{jr_addr[1:0], ifid_pc4_q[1:0]};

    // Control flow decided in ID only counts when ID holds a live instruction
    assign redirect = ifid_valid_q
                    & ((npc_sel == 2'b01 & br_taken) | npc_sel[1]);
    assign pc_inc = pc_q + 30'd1;

    always_comb begin
        target = jr_addr[31:2];
        case (npc_sel)
            2'b01:   target = ifid_pc4_q[31:2] + {{14{imm16[15]}}, imm16};
            2'b10:   target = {ifid_pc4_q[31:28], jidx};
            default: target = jr_addr[31:2];
        endcase
    end

    always_comb begin
        pc_d = pc_inc;
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = target;
        end
    end

    always_comb begin
        ifid_ir_d    = ifid_ir_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        load         = 1'b0;
        if (flush) begin
            ifid_ir_d    = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            ifid_ir_d    = ifid_ir_q;
        end else if (redirect) begin
            ifid_ir_d    = 32'd0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_ir_d    = im_ir;
            ifid_pc4_d   = {pc_inc, 2'b00};
            ifid_valid_d = 1'b1;
            load         = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC[31:2];
            ifid_ir_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_ir    = ifid_ir_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, load};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_load;
    assign unused_load = load;
    assign fetch_cnt   = 32'd0;
    assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// control stimulus against a byte-address reference model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] jidx = 26'd0;
    logic [31:0] jr_addr = 32'd0;
    logic [29:0] pc;
    logic [31:0] im_ir;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    logic [29:0] pc_w;
    logic [31:0] im_ir_w;
    logic [31:0] ifid_ir_w;
    logic [31:0] ifid_pc4_w;
    logic        ifid_valid_w;
    logic [31:0] fetch_cnt_w;
    logic [31:0] stall_cnt_w;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Reference model state, byte addresses
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    always #5 clock = ~clock;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    always_comb im_ir = imem({pc, 2'b00});
    always_comb im_ir_w = imem({pc_w, 2'b00});

    fetch_unit u_dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .npc_sel(npc_sel), .br_taken(br_taken), .imm16(imm16),
        .jidx(jidx), .jr_addr(jr_addr), .pc(pc), .im_ir(im_ir),
        .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .npc_sel(npc_sel), .br_taken(br_taken), .imm16(imm16),
        .jidx(jidx), .jr_addr(jr_addr), .pc(pc_w), .im_ir(im_ir_w),
        .ifid_ir(ifid_ir_w), .ifid_pc4(ifid_pc4_w),
        .ifid_valid(ifid_valid_w),
        .fetch_cnt(fetch_cnt_w), .stall_cnt(stall_cnt_w)
    );

    task automatic model_reset();
        m_pc = 32'h0;
        m_ir = 32'h0;
        m_pc4 = 32'h0;
        m_valid = 1'b0;
        m_fcnt = 32'h0;
        m_scnt = 32'h0;
    endtask

    task automatic model_step();
        logic redir;
        logic [31:0] tgt;
        int off;
        redir = m_valid && ((npc_sel == 2'b01 && br_taken) || npc_sel >= 2'b10);
        off = int'(signed'(imm16));
        case (npc_sel)
            2'b01: tgt = m_pc4 + 32'(off * 4);
            2'b10: tgt = (m_pc4 & 32'hF000_0000) | (32'(jidx) << 2);
            default: tgt = jr_addr;
        endcase
        if (flush) begin
            m_valid = 1'b0;
            m_ir = 32'h0;
        end else if (!stall) begin
            if (redir) begin
                m_valid = 1'b0;
                m_ir = 32'h0;
            end else begin
                m_ir = imem(m_pc);
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_fcnt = m_fcnt + 32'd1;
            end
        end
        if (stall) m_scnt = m_scnt + 32'd1;
        else if (redir) m_pc = tgt & 32'hFFFF_FFFC;
        else m_pc = m_pc + 32'd4;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        npc_sel = 2'b00;
        br_taken = 1'b0;
        model_reset();
        #2;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        tick();
        reset = 1'b1;
        #2;
        n_cmp++;
        if (pc !== 30'h0) begin
            n_bad++;
            $display("FAIL reset_pc got %h want 0", pc);
        end
        n_cmp++;
        if (ifid_ir !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ifid got ir=%h pc4=%h v=%b want 0/0/0",
                     ifid_ir, ifid_pc4, ifid_valid);
        end
        n_cmp++;
        if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cnt got f=%0d s=%0d want 0/0", fetch_cnt, stall_cnt);
        end
        n_cmp++;
        if (pc_w !== 30'h3FFF_FFFF) begin
            n_bad++;
            $display("FAIL reset_pc_param got %h want 3fffffff", pc_w);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_f;
        do_reset();
        n_cmp++;
        if (pc !== 30'd0) begin
            n_bad++;
            $display("FAIL seq_pc0 got %0d want 0", pc);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (pc !== 30'(i) || ifid_pc4 !== 32'(4 * i) || ifid_valid !== 1'b1
                || ifid_ir !== imem(32'(4 * (i - 1)))) begin
                n_bad++;
                $display("FAIL seq_step%0d got pc=%0d pc4=%0d v=%b ir=%h want %0d/%0d/1/%h",
                         i, pc, ifid_pc4, ifid_valid, ifid_ir, i, 4 * i,
                         imem(32'(4 * (i - 1))));
            end
        end
        exp_f = PERF ? 32'd4 : 32'd0;
        n_cmp++;
        if (fetch_cnt !== exp_f) begin
            n_bad++;
            $display("FAIL seq_fetch_cnt got %0d want %0d", fetch_cnt, exp_f);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) tick();
        npc_sel = 2'b01;
        br_taken = 1'b0;
        imm16 = 16'hFFFC;
        tick();
        n_cmp++;
        if (pc !== 30'd5 || ifid_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL br_not_taken got pc=%0d v=%b want 5/1", pc, ifid_valid);
        end
        do_reset();
        repeat (4) tick();
        npc_sel = 2'b01;
        br_taken = 1'b1;
        imm16 = 16'hFFFC;
        tick();
        npc_sel = 2'b00;
        br_taken = 1'b0;
        n_cmp++;
        if (pc !== 30'h0 || ifid_valid !== 1'b0 || ifid_ir !== 32'h0) begin
            n_bad++;
            $display("FAIL br_taken got pc=%h v=%b ir=%h want 0/0/0",
                     pc, ifid_valid, ifid_ir);
        end
        tick();
        n_cmp++;
        if (ifid_ir !== imem(32'h0) || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4) begin
            n_bad++;
            $display("FAIL br_target_ir got ir=%h v=%b pc4=%h want %h/1/4",
                     ifid_ir, ifid_valid, ifid_pc4, imem(32'h0));
        end
    endtask

    task automatic test_jump();
        do_reset();
        tick();
        npc_sel = 2'b11;
        jr_addr = 32'h3000_0000;
        tick();
        npc_sel = 2'b00;
        tick();
        n_cmp++;
        if (ifid_pc4 !== 32'h3000_0004 || ifid_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL jump_setup got pc4=%h v=%b want 30000004/1", ifid_pc4, ifid_valid);
        end
        npc_sel = 2'b10;
        jidx = 26'h0000100;
        tick();
        npc_sel = 2'b00;
        n_cmp++;
        if ({pc, 2'b00} !== 32'h3000_0400 || ifid_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_target got %h v=%b want 30000400/0", {pc, 2'b00}, ifid_valid);
        end
    endtask

    task automatic test_stall_jr();
        logic [29:0] hp;
        logic [31:0] hir;
        logic [31:0] hp4;
        logic [31:0] exp_s;
        do_reset();
        tick();
        tick();
        hp = pc;
        hir = ifid_ir;
        hp4 = ifid_pc4;
        stall = 1'b1;
        npc_sel = 2'b11;
        jr_addr = 32'h40;
        repeat (3) begin
            tick();
            n_cmp++;
            if (pc !== hp || ifid_ir !== hir || ifid_pc4 !== hp4 || ifid_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold got pc=%h ir=%h pc4=%h v=%b want %h/%h/%h/1",
                         pc, ifid_ir, ifid_pc4, ifid_valid, hp, hir, hp4);
            end
        end
        exp_s = PERF ? 32'd3 : 32'd0;
        n_cmp++;
        if (stall_cnt !== exp_s) begin
            n_bad++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_s);
        end
        stall = 1'b0;
        tick();
        npc_sel = 2'b00;
        n_cmp++;
        if (pc !== 30'h10 || ifid_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release got pc=%h v=%b want 10/0", pc, ifid_valid);
        end
    endtask

    task automatic test_flush();
        logic [29:0] hp;
        logic [31:0] hp4;
        do_reset();
        tick();
        tick();
        hp = pc;
        hp4 = ifid_pc4;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (ifid_valid !== 1'b0 || ifid_ir !== 32'h0 || pc !== hp + 30'd1
            || ifid_pc4 !== hp4) begin
            n_bad++;
            $display("FAIL flush got v=%b ir=%h pc=%h pc4=%h want 0/0/%h/%h",
                     ifid_valid, ifid_ir, pc, ifid_pc4, hp + 30'd1, hp4);
        end
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if (ifid_valid !== 1'b0 || pc !== hp + 30'd1) begin
            n_bad++;
            $display("FAIL flush_stall got v=%b pc=%h want 0/%h", ifid_valid, pc, hp + 30'd1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_cmp++;
        if (pc_w !== 30'h3FFF_FFFF) begin
            n_bad++;
            $display("FAIL wrap_reset got %h want 3fffffff", pc_w);
        end
        tick();
        n_cmp++;
        if (pc_w !== 30'h0 || ifid_pc4_w !== 32'h0 || ifid_valid_w !== 1'b1
            || ifid_ir_w !== imem(32'hFFFF_FFFC)) begin
            n_bad++;
            $display("FAIL wrap got pc=%h pc4=%h v=%b ir=%h want 0/0/1/%h",
                     pc_w, ifid_pc4_w, ifid_valid_w, ifid_ir_w, imem(32'hFFFF_FFFC));
        end
    endtask

    task automatic rand_inputs();
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 9) == 0);
        npc_sel = 2'($urandom_range(0, 3));
        br_taken = 1'($urandom_range(0, 1));
        imm16 = 16'($urandom);
        jidx = 26'($urandom);
        jr_addr = $urandom;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            tick();
            n_cmp++;
            if (pc !== m_pc[31:2] || ifid_ir !== m_ir || ifid_pc4 !== m_pc4
                || ifid_valid !== m_valid) begin
                n_bad++;
                $display("FAIL rand_%0d got pc=%h ir=%h pc4=%h v=%b want %h/%h/%h/%b",
                         i, pc, ifid_ir, ifid_pc4, ifid_valid,
                         m_pc[31:2], m_ir, m_pc4, m_valid);
            end
            n_cmp++;
            if (fetch_cnt !== (PERF ? m_fcnt : 32'd0)
                || stall_cnt !== (PERF ? m_scnt : 32'd0)) begin
                n_bad++;
                $display("FAIL rand_cnt_%0d got f=%0d s=%0d want %0d/%0d",
                         i, fetch_cnt, stall_cnt,
                         PERF ? m_fcnt : 32'd0, PERF ? m_scnt : 32'd0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        repeat (20) begin
            rand_inputs();
            tick();
        end
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        npc_sel = 2'b00;
        #2;
        n_cmp++;
        if (pc !== 30'h0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0
            || fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset got pc=%h v=%b pc4=%h f=%0d s=%0d want all 0",
                     pc, ifid_valid, ifid_pc4, fetch_cnt, stall_cnt);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        n_cmp++;
        if (pc !== 30'd1 || ifid_pc4 !== 32'd4 || ifid_ir !== imem(32'h0)
            || ifid_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_first_fetch got pc=%h pc4=%h ir=%h v=%b want 1/4/%h/1",
                     pc, ifid_pc4, ifid_ir, ifid_valid, imem(32'h0));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_jr();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core. Owns the program counter, drives the word address into the instruction memory `im`, and captures the returned instruction into the IF/ID pipeline register. Next-PC selection covers sequential, taken-branch, jump and register-jump. Decode/execute resolve control flow and feed the decisions back. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] ignored.

Ports:
- `clock`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID register this cycle.
- `flush`  in  1  squash IF/ID contents this cycle.
- `npc_sel`  in  2  00 seq, 01 branch, 10 jump (j/jal), 11 register jump (jr).
- `br_taken`  in  1  branch condition result; qualifies `npc_sel`=01.
- `imm16`  in  16  branch offset field of the instruction in ID.
- `jidx`  in  26  jump index field of the instruction in ID.
- `jr_addr`  in  32  register-jump target byte address.
- `pc`  out  30  word address [31:2], to `im`.
- `im_ir`  in  32  instruction returned combinationally by `im` for `pc`.
- `ifid_ir`  out  32  registered instruction to ID.
- `ifid_pc4`  out  32  registered byte address of that instruction + 4.
- `ifid_valid`  out  1  IF/ID holds a live instruction.
- `fetch_cnt`  out  32  fetched-instruction counter (see Configuration).
- `stall_cnt`  out  32  stall-cycle counter (see Configuration).

## Operation
- Redirect condition: `redirect` = (`npc_sel`=01 & `br_taken`) | `npc_sel`=10 | `npc_sel`=11.
- Target computation uses `ifid_pc4` as base:
  - Branch: `ifid_pc4` + (sign-extended `imm16` << 2), 32-bit modular.
  - Jump: {`ifid_pc4`[31:28], `jidx`, 2'b00}.
  - Register jump: `jr_addr`.
  - Only bits [31:2] are loaded into `pc`.
- `npc_sel`=01 with `br_taken`=0 is sequential.
- Next PC:
  - `stall`=1: hold.
  - Else `redirect`: target.
  - Else `pc`+1, wrapping 30'h3FFF_FFFF -> 0.
- IF/ID update, in priority order:
  - `flush`=1: `ifid_valid`<=0 and `ifid_ir`<=0 (nop); `ifid_pc4` holds.
  - Else `stall`=1: hold all.
  - Else `redirect`: `ifid_valid`<=0 and `ifid_ir`<=0. The wrong-path instruction is squashed; there is no delay slot.
  - Else load `ifid_ir`<=`im_ir`, `ifid_pc4`<={`pc`+1, 2'b00}, `ifid_valid`<=1.
- Simultaneous `stall` and `redirect`: stall wins and the redirect is dropped. ID holds the instruction and re-asserts the redirect on the next unstalled cycle.
- Simultaneous `flush` and `stall`: PC holds and IF/ID is squashed.
- Behaviour for `npc_sel`/`br_taken` while `ifid_valid`=0: ignored, treated as sequential.

## Timing
- Reset (asynchronous, immediate):
  - `pc`=`RESET_PC`[31:2].
  - `ifid_ir`=0, `ifid_pc4`=0, `ifid_valid`=0.
  - `fetch_cnt`=0, `stall_cnt`=0.
- Reset deasserted mid-stream: the first fetch is from `RESET_PC` on the following edge; no partial state survives.
- Fetch latency: `im_ir` is sampled at the edge ending the cycle in which `pc` is presented. The instruction appears at `ifid_ir` one cycle after `pc` shows its address.
- Redirect penalty: one bubble cycle. The target appears on `pc` the cycle after `redirect` is seen, and the target instruction reaches `ifid_ir` one cycle later.
- No combinational path from `im_ir` to `pc`. Combinational paths exist from `npc_sel`, `br_taken`, `imm16`, `jidx`, `jr_addr` and `stall` into next-PC logic only.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every edge where IF/ID loads a live instruction (valid<=1).
  - `stall_cnt` increments on every edge with `stall`=1 and `reset`=0.
  - Both wrap modulo 2^32.
- `FETCH_PERF_CNT_EN` undefined: counters are not built; `fetch_cnt` and `stall_cnt` are tied to 0 and the ports remain.

## Test plan
- Reset, then 5 free-running cycles with `npc_sel`=00:
  - `pc` 0,1,2,3,4.
  - `ifid_pc4` 4,8,12,16.
  - `ifid_valid`=1 from the second edge.
  - `fetch_cnt`=4 with `FETCH_PERF_CNT_EN`.
- Taken branch with `ifid_pc4`=32'h10 and `imm16`=16'hFFFC:
  - Next `pc`=30'h0 (byte 0x0).
  - Following `ifid_valid`=0, `ifid_ir`=0.
- Jump with `ifid_pc4`=32'h3000_0004 and `jidx`=26'h0000100: next `pc` byte address = 32'h3000_0400.
- `stall`=1 for 3 cycles together with `npc_sel`=11 and `jr_addr`=32'h40:
  - `pc` and IF/ID hold.
  - `stall_cnt`=3.
  - After release, `pc`=30'h10.
- `flush`=1 with `stall`=0: `ifid_valid`=0, `ifid_ir`=0, `pc` advances by 1.
- `RESET_PC`=32'hFFFF_FFFC, one sequential cycle: `pc` wraps to 0; `ifid_pc4`=0.
